// File: rtl/stage3_fetch_pkg.sv
// Shared types for the stage-3 prefetching fetch unit.
package stage3_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    logic        fault;
    logic        mal;
    logic [31:0] badaddr;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } inflight_meta_t;

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO with flush; simultaneous push and pop is legal even when full.
module fetch_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stage3_prefetch_fetch_unit.sv
// Decoupled fetch front end: pipelined instruction-bus master feeding an
// instruction queue, with a drain counter that discards responses owed at redirect.
module stage3_prefetch_fetch_unit
  import stage3_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned FETCH_Q_DEPTH   = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        out_pred,
  output logic        out_fault,
  output logic        out_mal,
  output logic [31:0] out_badaddr
);

  localparam int unsigned QCW = $clog2(FETCH_Q_DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]    fetch_pc;
  logic           halted;
  logic [OCW-1:0] outstanding, drop_cnt;
  logic [QCW-1:0] q_count;
  logic           q_full, q_empty, meta_full, meta_empty;
  logic           issue, misaligned, grant, mal_push, resp_keep, q_push, q_pop;
  fetch_entry_t   q_wdata, q_head, head_vis;
  inflight_meta_t meta_wdata, meta_head;

  always_comb begin
    issue      = !RST && !redirect && !halted && !meta_full &&
                 ((32'(outstanding) + 32'(q_count)) < FETCH_Q_DEPTH);
    misaligned = (fetch_pc[1:0] != 2'b00);
    imem_req   = issue && !misaligned;
    imem_addr  = fetch_pc;
    pred_pc    = fetch_pc;
    grant      = imem_req && imem_gnt;
    // Misaligned entry waits for older responses so program order is kept
    // and the queue only ever sees one write per cycle.
    mal_push   = issue && misaligned && (outstanding == '0);
    resp_keep  = imem_rvalid && (drop_cnt == '0);
    q_push     = !redirect && (resp_keep || mal_push);
    q_pop      = !q_empty && out_ready;

    meta_wdata      = '0;
    meta_wdata.pc   = fetch_pc;
    meta_wdata.pred = pred_taken;

    q_wdata = '0;
    if (mal_push) begin
      q_wdata.pc      = fetch_pc;
      q_wdata.pc4     = fetch_pc + 32'd4;
      q_wdata.mal     = 1'b1;
      q_wdata.badaddr = fetch_pc;
    end else begin
      q_wdata.instr   = imem_error ? '0 : imem_rdata;
      q_wdata.pc      = meta_head.pc;
      q_wdata.pc4     = meta_head.pc + 32'd4;
      q_wdata.pred    = meta_head.pred;
      q_wdata.fault   = imem_error;
      q_wdata.badaddr = meta_head.pc;
    end

    head_vis    = q_empty ? '0 : q_head;
    out_valid   = !q_empty;
    out_instr   = head_vis.instr;
    out_pc      = head_vis.pc;
    out_pc4     = head_vis.pc4;
    out_pred    = head_vis.pred;
    out_fault   = head_vis.fault;
    out_mal     = head_vis.mal;
    out_badaddr = head_vis.badaddr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      halted   <= 1'b0;
      // Every response still owed after this cycle is stale.
      drop_cnt <= outstanding - OCW'(imem_rvalid);
    end else begin
      if (grant) fetch_pc <= pred_taken ? pred_target : fetch_pc + 32'd4;
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
      if (mal_push || (resp_keep && imem_error)) halted <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(imem_rvalid && meta_empty));
      assert (!(q_push && q_full && !q_pop));
    end
  end

  fetch_sync_fifo #(
    .WIDTH ($bits(inflight_meta_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_q (
    .clk       (CLK),
    .rst       (RST),
    .flush     (1'b0),
    .push      (grant),
    .push_data (meta_wdata),
    .pop       (imem_rvalid),
    .pop_data  (meta_head),
    .full      (meta_full),
    .empty     (meta_empty),
    .count     (outstanding)
  );

  fetch_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FETCH_Q_DEPTH)
  ) u_instr_q (
    .clk       (CLK),
    .rst       (RST),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule
